// File: rtl/dma_timing_ctrl_pkg.sv
// Shared types and constants for the DMA transfer sequencer.
// Transfer states, mode/type encodings and a channel one-hot helper.
package dma_timing_ctrl_pkg;

  typedef enum logic [2:0] {
    SI, S0, S1, S2, S3, S4, SC
  } dmaState_t;

  localparam logic [1:0] MODE_DEMAND  = 2'b00;
  localparam logic [1:0] MODE_SINGLE  = 2'b01;
  localparam logic [1:0] MODE_BLOCK   = 2'b10;
  localparam logic [1:0] MODE_CASCADE = 2'b11;

  localparam logic [1:0] TYPE_VERIFY = 2'b00;
  localparam logic [1:0] TYPE_WRITE  = 2'b01;
  localparam logic [1:0] TYPE_READ   = 2'b10;

  function automatic logic [3:0] onehot4(input logic [1:0] ch);
    onehot4 = 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_strobe_decode.sv
// Combinational map from transfer state and transfer type to bus strobes.
// Read strobe spans S2-S3, write strobe S3 only; verify drives none.
module dma_strobe_decode
  import dma_timing_ctrl_pkg::*;
(
  input  dmaState_t  state,
  input  logic [1:0] act_type,
  output logic       memr_n,
  output logic       memw_n,
  output logic       ior_n,
  output logic       iow_n
);

  logic rd;
  logic wr;
  logic is_write;
  logic is_read;

  assign rd       = (state == S2) || (state == S3);
  assign wr       = (state == S3);
  assign is_write = (act_type == TYPE_WRITE);
  assign is_read  = (act_type == TYPE_READ);

  always_comb begin
    memr_n = 1'b1;
    memw_n = 1'b1;
    ior_n  = 1'b1;
    iow_n  = 1'b1;
    unique case (1'b1)
      is_write: begin
        ior_n  = !rd;
        memw_n = !wr;
      end
      is_read: begin
        memr_n = !rd;
        iow_n  = !wr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dma_timing_ctrl.sv
// 8237-style transfer sequencer: HRQ/HLDA handshake, S0-S4 word timing,
// strobes, DACK and step/done pulses, all registered from next state.
module dma_timing_ctrl
  import dma_timing_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       reqValid,
  input  logic [1:0] reqCh,
  input  logic       dreqLevel,
  input  logic [1:0] xferMode,
  input  logic [1:0] xferType,
  input  logic       tc,
  input  logic       HLDA,
  input  logic       EOP_N_IN,
  output logic       HRQ,
  output logic       AEN,
  output logic       ADSTB,
  output logic [3:0] DACK,
  output logic       MEMR_N,
  output logic       MEMW_N,
  output logic       IOR_N,
  output logic       IOW_N,
  output logic       EOP_N_OUT,
  output logic       addrStep,
  output logic       countStep,
  output logic       chDone,
  output logic [1:0] chDoneCh
);

  dmaState_t  state;
  dmaState_t  next;
  logic [1:0] act_ch;
  logic [1:0] act_mode;
  logic [1:0] act_type;
  logic       eop_seen;
  logic       eop_seen_d;
  logic       latch;
  logic       term;
  logic       done_d;
  logic       xfer;
  logic       memr_d;
  logic       memw_d;
  logic       ior_d;
  logic       iow_d;

  always_comb begin
    next   = state;
    latch  = 1'b0;
    done_d = 1'b0;
    term   = eop_seen || !EOP_N_IN || tc;
    unique case (state)
      SI: if (reqValid) begin
        next  = S0;
        latch = 1'b1;
      end
      S0: begin
        if (HLDA)
          next = (act_mode == MODE_CASCADE) ? SC : S1;
        else if (!reqValid)
          next = SI;
      end
      S1: next = HLDA ? S2 : SI;
      S2: next = HLDA ? S3 : SI;
      S3: next = HLDA ? S4 : SI;
      S4: begin
        if (!HLDA) begin
          next = SI;
        end else if (term) begin
          next   = SI;
          done_d = 1'b1;
        end else begin
          case (act_mode)
            MODE_BLOCK:  next = S1;
            MODE_DEMAND: next = dreqLevel ? S1 : SI;
            default:     next = SI;
          endcase
        end
      end
      SC: if (!HLDA || !dreqLevel) next = SI;
      default: next = SI;
    endcase
  end

  // EOP seen early in the word is remembered until the S4 decision
  assign eop_seen_d = ((state == S2) || (state == S3)) &&
                      (eop_seen || !EOP_N_IN);
  assign xfer = (next == S1) || (next == S2) ||
                (next == S3) || (next == S4);

  dma_strobe_decode u_strobe (
    .state    (next),
    .act_type (act_type),
    .memr_n   (memr_d),
    .memw_n   (memw_d),
    .ior_n    (ior_d),
    .iow_n    (iow_d)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= SI;
      act_ch    <= 2'b00;
      act_mode  <= 2'b00;
      act_type  <= 2'b00;
      eop_seen  <= 1'b0;
      HRQ       <= 1'b0;
      AEN       <= 1'b0;
      ADSTB     <= 1'b0;
      DACK      <= 4'b0000;
      MEMR_N    <= 1'b1;
      MEMW_N    <= 1'b1;
      IOR_N     <= 1'b1;
      IOW_N     <= 1'b1;
      EOP_N_OUT <= 1'b1;
      addrStep  <= 1'b0;
      countStep <= 1'b0;
      chDone    <= 1'b0;
      chDoneCh  <= 2'b00;
    end else begin
      state    <= next;
      eop_seen <= eop_seen_d;
      if (latch) begin
        act_ch   <= reqCh;
        act_mode <= xferMode;
        act_type <= xferType;
      end
      HRQ       <= (next != SI);
      AEN       <= xfer;
      ADSTB     <= (next == S1);
      DACK      <= (xfer || next == SC) ? onehot4(act_ch) : 4'b0000;
      MEMR_N    <= memr_d;
      MEMW_N    <= memw_d;
      IOR_N     <= ior_d;
      IOW_N     <= iow_d;
      EOP_N_OUT <= !((next == S4) && tc);
      addrStep  <= (next == S4);
      countStep <= (next == S4);
      chDone    <= done_d;
      if (done_d)
        chDoneCh <= act_ch;
    end
  end

endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed bench for dma_timing_ctrl.
// Output vector: HRQ AEN ADSTB DACK[3:0] MEMR MEMW IOR IOW EOP aStep cStep done ch[1:0]
module tb_dma_timing_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       reqValid;
  logic [1:0] reqCh;
  logic       dreqLevel;
  logic [1:0] xferMode;
  logic [1:0] xferType;
  logic       tc;
  logic       HLDA;
  logic       EOP_N_IN;
  logic       HRQ;
  logic       AEN;
  logic       ADSTB;
  logic [3:0] DACK;
  logic       MEMR_N;
  logic       MEMW_N;
  logic       IOR_N;
  logic       IOW_N;
  logic       EOP_N_OUT;
  logic       addrStep;
  logic       countStep;
  logic       chDone;
  logic [1:0] chDoneCh;

  int checks = 0;
  int errors = 0;

  logic [16:0] outs;
  logic [16:0] exp_v;

  assign outs = {HRQ, AEN, ADSTB, DACK, MEMR_N, MEMW_N, IOR_N, IOW_N,
                 EOP_N_OUT, addrStep, countStep, chDone, chDoneCh};

  dma_timing_ctrl dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .reqValid  (reqValid),
    .reqCh     (reqCh),
    .dreqLevel (dreqLevel),
    .xferMode  (xferMode),
    .xferType  (xferType),
    .tc        (tc),
    .HLDA      (HLDA),
    .EOP_N_IN  (EOP_N_IN),
    .HRQ       (HRQ),
    .AEN       (AEN),
    .ADSTB     (ADSTB),
    .DACK      (DACK),
    .MEMR_N    (MEMR_N),
    .MEMW_N    (MEMW_N),
    .IOR_N     (IOR_N),
    .IOW_N     (IOW_N),
    .EOP_N_OUT (EOP_N_OUT),
    .addrStep  (addrStep),
    .countStep (countStep),
    .chDone    (chDone),
    .chDoneCh  (chDoneCh)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input logic [1:0] ch, input logic [1:0] md,
                       input logic [1:0] ty);
    reqValid = 1'b1;
    reqCh    = ch;
    xferMode = md;
    xferType = ty;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL reset got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_00);
    end
    RESET_N = 1'b1;
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL idle got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_00);
    end
  endtask

  task automatic test_s0_abort();
    start(2'd1, 2'b01, 2'b01);
    HLDA = 1'b0;
    tick();
    checks++;
    if (outs !== 17'b1_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL s0_hrq got %b exp %b", outs, 17'b1_0_0_0000_1111_1_00_0_00);
    end
    reqValid = 1'b0;
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL s0_abort got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_00);
    end
  endtask

  task automatic test_single_write();
    logic [16:0] seq [6];
    seq[0] = 17'b1_0_0_0000_1111_1_00_0_00;
    seq[1] = 17'b1_1_1_0100_1111_1_00_0_00;
    seq[2] = 17'b1_1_0_0100_1101_1_00_0_00;
    seq[3] = 17'b1_1_0_0100_1001_1_00_0_00;
    seq[4] = 17'b1_1_0_0100_1111_1_11_0_00;
    seq[5] = 17'b0_0_0_0000_1111_1_00_0_00;
    start(2'd2, 2'b01, 2'b01);
    HLDA = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) HLDA = 1'b1;
      if (i == 1) reqValid = 1'b0;
      checks++;
      if (outs !== seq[i]) begin
        errors++;
        $display("FAIL single_wr[%0d] got %b exp %b", i, outs, seq[i]);
      end
    end
    HLDA = 1'b0;
  endtask

  task automatic test_block_read_tc();
    int aen_cnt = 0;
    int step_cnt = 0;
    start(2'd0, 2'b10, 2'b10);
    HLDA = 1'b1;
    tick();
    tick();
    reqValid = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int s = 0; s < 4; s++) begin
        case (s)
          0: exp_v = 17'b1_1_1_0001_1111_1_00_0_00;
          1: exp_v = 17'b1_1_0_0001_0111_1_00_0_00;
          2: exp_v = 17'b1_1_0_0001_0110_1_00_0_00;
          default: exp_v = {12'b1_1_0_0001_1111, (w != 2), 4'b11_0_0, 1'b0};
        endcase
        checks++;
        if (outs !== exp_v) begin
          errors++;
          $display("FAIL block_rd w%0d s%0d got %b exp %b", w, s, outs, exp_v);
        end
        aen_cnt += int'(AEN);
        step_cnt += int'(countStep);
        if (s == 0 && w == 2) tc = 1'b1;
        tick();
      end
    end
    tc = 1'b0;
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_1_00) begin
      errors++;
      $display("FAIL block_rd_done got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_1_00);
    end
    checks++;
    if (aen_cnt != 12 || step_cnt != 3) begin
      errors++;
      $display("FAIL block_rd_counts got %0d/%0d exp 12/3", aen_cnt, step_cnt);
    end
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL block_rd_pulse got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_00);
    end
    HLDA = 1'b0;
  endtask

  task automatic test_demand();
    start(2'd1, 2'b00, 2'b01);
    HLDA = 1'b1;
    dreqLevel = 1'b1;
    tick();
    tick();
    reqValid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      for (int s = 0; s < 4; s++) begin
        case (s)
          0: exp_v = 17'b1_1_1_0010_1111_1_00_0_00;
          1: exp_v = 17'b1_1_0_0010_1101_1_00_0_00;
          2: exp_v = 17'b1_1_0_0010_1001_1_00_0_00;
          default: exp_v = 17'b1_1_0_0010_1111_1_11_0_00;
        endcase
        checks++;
        if (outs !== exp_v) begin
          errors++;
          $display("FAIL demand w%0d s%0d got %b exp %b", w, s, outs, exp_v);
        end
        if (s == 1 && w == 1) dreqLevel = 1'b0;
        tick();
      end
    end
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL demand_end got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_00);
    end
    dreqLevel = 1'b1;
    HLDA = 1'b0;
  endtask

  task automatic test_ext_eop();
    start(2'd1, 2'b10, 2'b00);
    HLDA = 1'b1;
    tick();
    tick();
    reqValid = 1'b0;
    tick();
    EOP_N_IN = 1'b0;
    checks++;
    if (outs !== 17'b1_1_0_0010_1111_1_00_0_00) begin
      errors++;
      $display("FAIL eop_s2 got %b exp %b", outs, 17'b1_1_0_0010_1111_1_00_0_00);
    end
    tick();
    EOP_N_IN = 1'b1;
    tick();
    checks++;
    if (outs !== 17'b1_1_0_0010_1111_1_11_0_00) begin
      errors++;
      $display("FAIL eop_s4 got %b exp %b", outs, 17'b1_1_0_0010_1111_1_11_0_00);
    end
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_1_01) begin
      errors++;
      $display("FAIL eop_done got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_1_01);
    end
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_01) begin
      errors++;
      $display("FAIL eop_idle got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_01);
    end
    HLDA = 1'b0;
  endtask

  task automatic test_hlda_drop();
    start(2'd2, 2'b10, 2'b01);
    HLDA = 1'b1;
    tick();
    tick();
    reqValid = 1'b0;
    tick();
    checks++;
    if (outs !== 17'b1_1_0_0100_1101_1_00_0_01) begin
      errors++;
      $display("FAIL hlda_s2 got %b exp %b", outs, 17'b1_1_0_0100_1101_1_00_0_01);
    end
    HLDA = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (outs !== 17'b0_0_0_0000_1111_1_00_0_01) begin
        errors++;
        $display("FAIL hlda_abort[%0d] got %b exp %b", i, outs, 17'b0_0_0_0000_1111_1_00_0_01);
      end
    end
  endtask

  task automatic test_cascade();
    start(2'd3, 2'b11, 2'b10);
    HLDA = 1'b1;
    dreqLevel = 1'b1;
    tick();
    checks++;
    if (outs !== 17'b1_0_0_0000_1111_1_00_0_01) begin
      errors++;
      $display("FAIL casc_s0 got %b exp %b", outs, 17'b1_0_0_0000_1111_1_00_0_01);
    end
    reqValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (outs !== 17'b1_0_0_1000_1111_1_00_0_01) begin
        errors++;
        $display("FAIL casc_sc[%0d] got %b exp %b", i, outs, 17'b1_0_0_1000_1111_1_00_0_01);
      end
    end
    dreqLevel = 1'b0;
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_01) begin
      errors++;
      $display("FAIL casc_end got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_01);
    end
    dreqLevel = 1'b1;
    HLDA = 1'b0;
  endtask

  task automatic test_reset_mid();
    start(2'd0, 2'b10, 2'b10);
    HLDA = 1'b1;
    tick();
    tick();
    reqValid = 1'b0;
    tick();
    tick();
    checks++;
    if (outs !== 17'b1_1_0_0001_0110_1_00_0_01) begin
      errors++;
      $display("FAIL rst_s3 got %b exp %b", outs, 17'b1_1_0_0001_0110_1_00_0_01);
    end
    RESET_N = 1'b0;
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL rst_mid got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_00);
    end
    RESET_N = 1'b1;
    HLDA = 1'b0;
    tick();
    checks++;
    if (outs !== 17'b0_0_0_0000_1111_1_00_0_00) begin
      errors++;
      $display("FAIL rst_after got %b exp %b", outs, 17'b0_0_0_0000_1111_1_00_0_00);
    end
  endtask

  initial begin
    RESET_N   = 1'b0;
    reqValid  = 1'b0;
    reqCh     = 2'd0;
    dreqLevel = 1'b1;
    xferMode  = 2'b00;
    xferType  = 2'b00;
    tc        = 1'b0;
    HLDA      = 1'b0;
    EOP_N_IN  = 1'b1;
    test_reset();
    test_s0_abort();
    test_single_write();
    test_block_read_tc();
    test_demand();
    test_ext_eop();
    test_hlda_drop();
    test_cascade();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
